// File: rtl/req_encoder_8to3.sv
// Sequential 8-to-3 request encoder: collects multi-hot requests and serializes them as 3-bit codes.
// Optional macro REQ_ENC_ROUND_ROBIN_EN selects round-robin arbitration instead of fixed priority.
module req_encoder_8to3 (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [7:0] req,
    input  logic       ready,
    output logic [2:0] y,
    output logic       valid,
    output logic [7:0] pending,
    output logic       overflow
);

    localparam int unsigned REQ_W  = 8;
    localparam int unsigned CODE_W = 3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [CODE_W-1:0]   y_q, y_d;
    logic                valid_q, valid_d;
    logic [REQ_W-1:0]    pending_q, pending_d;
    logic                overflow_q, overflow_d;
    logic [REQ_W-1:0]    clr_c;
    logic [CODE_W-1:0]   sel_c;

`ifdef REQ_ENC_ROUND_ROBIN_EN
    logic [CODE_W-1:0]   last_q, last_d;

    // First set bit searching upward from last_grant+1, wrapping 7->0.
    always_comb begin
        logic [CODE_W-1:0] idx;
        sel_c = '0;
        for (int k = REQ_W - 1; k >= 0; k--) begin
            idx = last_q + CODE_W'(k + 1);
            if (pending_q[idx]) begin
                sel_c = idx;
            end
        end
    end
`else
    // Fixed priority: lowest-numbered set bit wins.
    always_comb begin
        sel_c = '0;
        for (int i = REQ_W - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                sel_c = CODE_W'(i);
            end
        end
    end
`endif

    // Next-state and output logic; set wins over clear on the accept edge.
    always_comb begin
        clr_c      = (valid_q && ready) ? (REQ_W'(1) << y_q) : '0;
        pending_d  = (pending_q & ~clr_c) | (enable ? req : '0);
        overflow_d = enable && (|(req & pending_q & ~clr_c));
        state_d    = state_q;
        y_d        = y_q;
        valid_d    = valid_q;
`ifdef REQ_ENC_ROUND_ROBIN_EN
        last_d     = last_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (enable && (pending_q != '0)) begin
                    y_d     = sel_c;
                    valid_d = 1'b1;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (ready) begin
                    valid_d = 1'b0;
                    state_d = ST_IDLE;
`ifdef REQ_ENC_ROUND_ROBIN_EN
                    last_d  = y_q;
`endif
                end
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            y_q        <= '0;
            valid_q    <= 1'b0;
            pending_q  <= '0;
            overflow_q <= 1'b0;
`ifdef REQ_ENC_ROUND_ROBIN_EN
            last_q     <= CODE_W'(7);
`endif
        end else begin
            state_q    <= state_d;
            y_q        <= y_d;
            valid_q    <= valid_d;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
`ifdef REQ_ENC_ROUND_ROBIN_EN
            last_q     <= last_d;
`endif
        end
    end

    assign y        = y_q;
    assign valid    = valid_q;
    assign pending  = pending_q;
    assign overflow = overflow_q;

endmodule
